// File: rtl/fat32_bpb_parser_if.sv
// Bus bundle between the FAT32 boot-sector parser and its neighbours:
// the SD sector reader (byte stream), the file-write engine (cluster
// translation) and whoever consumes the parsed volume geometry.
//
// Handshake semantics:
//   byte stream : byte_valid qualifies byte_addr/byte_data for one cycle.
//                 There is no back-pressure; the parser takes every
//                 qualified byte while capturing and drops it otherwise.
//   translation : cluster_req qualifies cluster_in for one cycle. When
//                 accepted, cluster_ack pulses exactly one cycle later
//                 with cluster_lba valid in that same cycle. A request
//                 made while no valid geometry is held is dropped and
//                 never acked. Requests may be issued every cycle.
interface fat32_bpb_parser_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int LBA_WIDTH  = 32
);
    logic                  start;
    logic [LBA_WIDTH-1:0]  partition_lba;
    logic                  byte_valid;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [7:0]            byte_data;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic [2:0]            error_code;
    logic [15:0]           reserved_sectors;
    logic [7:0]            num_fats;
    logic [31:0]           fat_length;
    logic [7:0]            sectors_per_cluster;
    logic [31:0]           root_cluster;
    logic [LBA_WIDTH-1:0]  fat_start_lba;
    logic [LBA_WIDTH-1:0]  data_start_lba;
    logic                  cluster_req;
    logic [31:0]           cluster_in;
    logic                  cluster_ack;
    logic [LBA_WIDTH-1:0]  cluster_lba;

    modport master (
        output start, partition_lba, byte_valid, byte_addr, byte_data,
               cluster_req, cluster_in,
        input  busy, done, valid, error_code, reserved_sectors, num_fats,
               fat_length, sectors_per_cluster, root_cluster, fat_start_lba,
               data_start_lba, cluster_ack, cluster_lba
    );

    modport slave (
        input  start, partition_lba, byte_valid, byte_addr, byte_data,
               cluster_req, cluster_in,
        output busy, done, valid, error_code, reserved_sectors, num_fats,
               fat_length, sectors_per_cluster, root_cluster, fat_start_lba,
               data_start_lba, cluster_ack, cluster_lba
    );
endinterface

// File: rtl/fat32_bpb_parser.sv
// FAT32 boot-sector (BPB) parser. Captures a streamed boot sector,
// validates it, derives FAT-start and data-region LBAs with an 8-cycle
// shift-add multiplier, and translates cluster numbers to LBAs.
// Optional feature macro: BPB_TOTSEC_CHECK_EN (TotSec32 range checking).
module fat32_bpb_parser #(
    parameter int SECTOR_SIZE = 512,
    parameter int ADDR_WIDTH  = 10,
    parameter int LBA_WIDTH   = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    fat32_bpb_parser_if.slave  bus,
    output logic [2:0]         state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_COMPUTE = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [LBA_WIDTH-1:0] part_lba;
    logic [15:0]          bps;
    logic [7:0]           spc;
    logic [15:0]          rsvd;
    logic [7:0]           nfats;
    logic [31:0]          fat_len;
    logic [31:0]          root_clus;
    logic                 sig_lo_ok, sig_hi_ok;
`ifdef BPB_TOTSEC_CHECK_EN
    logic [31:0]          tot_sec;
`endif
    logic [2:0]           mul_cnt;
    logic [LBA_WIDTH-1:0] product;
    logic [LBA_WIDTH-1:0] fat_start, data_start, data_nxt;
    logic [2:0]           err, err_nxt;
    logic                 valid_q, ack_q;
    logic [LBA_WIDTH-1:0] clus_lba, clus_off, clus_nxt;
    logic [2:0]           spc_log2;
    logic                 busy_w, capture_en, last_byte, xlate_ok;

    assign busy_w     = (state == S_CAPTURE) || (state == S_COMPUTE) || (state == S_CHECK);
    assign capture_en = (state == S_CAPTURE) && bus.byte_valid && !bus.start;
    assign last_byte  = capture_en && (bus.byte_addr == ADDR_WIDTH'(SECTOR_SIZE - 1));
    assign xlate_ok   = bus.cluster_req && valid_q && !busy_w;

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; start restarts capture from any state.
    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = S_CAPTURE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_IDLE;
                S_CAPTURE: if (last_byte) state_nxt = S_COMPUTE;
                S_COMPUTE: if (mul_cnt == 3'd7) state_nxt = S_CHECK;
                S_CHECK:   state_nxt = S_DONE;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Field capture: little-endian BPB decode of bytes arriving in any order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            part_lba  <= '0;
            bps       <= '0;
            spc       <= '0;
            rsvd      <= '0;
            nfats     <= '0;
            fat_len   <= '0;
            root_clus <= '0;
            sig_lo_ok <= 1'b0;
            sig_hi_ok <= 1'b0;
`ifdef BPB_TOTSEC_CHECK_EN
            tot_sec   <= '0;
`endif
        end else if (bus.start) begin
            part_lba  <= bus.partition_lba;
            sig_lo_ok <= 1'b0;
            sig_hi_ok <= 1'b0;
        end else if (capture_en) begin
            case (bus.byte_addr)
                ADDR_WIDTH'(11):  bps[7:0]        <= bus.byte_data;
                ADDR_WIDTH'(12):  bps[15:8]       <= bus.byte_data;
                ADDR_WIDTH'(13):  spc             <= bus.byte_data;
                ADDR_WIDTH'(14):  rsvd[7:0]       <= bus.byte_data;
                ADDR_WIDTH'(15):  rsvd[15:8]      <= bus.byte_data;
                ADDR_WIDTH'(16):  nfats           <= bus.byte_data;
`ifdef BPB_TOTSEC_CHECK_EN
                ADDR_WIDTH'(32):  tot_sec[7:0]    <= bus.byte_data;
                ADDR_WIDTH'(33):  tot_sec[15:8]   <= bus.byte_data;
                ADDR_WIDTH'(34):  tot_sec[23:16]  <= bus.byte_data;
                ADDR_WIDTH'(35):  tot_sec[31:24]  <= bus.byte_data;
`endif
                ADDR_WIDTH'(36):  fat_len[7:0]    <= bus.byte_data;
                ADDR_WIDTH'(37):  fat_len[15:8]   <= bus.byte_data;
                ADDR_WIDTH'(38):  fat_len[23:16]  <= bus.byte_data;
                ADDR_WIDTH'(39):  fat_len[31:24]  <= bus.byte_data;
                ADDR_WIDTH'(44):  root_clus[7:0]  <= bus.byte_data;
                ADDR_WIDTH'(45):  root_clus[15:8] <= bus.byte_data;
                ADDR_WIDTH'(46):  root_clus[23:16] <= bus.byte_data;
                ADDR_WIDTH'(47):  root_clus[31:24] <= bus.byte_data;
                ADDR_WIDTH'(510): sig_lo_ok       <= (bus.byte_data == 8'h55);
                ADDR_WIDTH'(511): sig_hi_ok       <= (bus.byte_data == 8'hAA);
                default:          ;
            endcase
        end
    end

    // Shift-add multiplier: one bit of num_fats per COMPUTE cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            product   <= '0;
            mul_cnt   <= '0;
            fat_start <= '0;
        end else if (last_byte) begin
            product   <= '0;
            mul_cnt   <= '0;
            fat_start <= part_lba + LBA_WIDTH'(rsvd);
        end else if (state == S_COMPUTE) begin
            if (nfats[mul_cnt]) product <= product + (LBA_WIDTH'(fat_len) << mul_cnt);
            mul_cnt <= mul_cnt + 3'd1;
        end
    end

    // Data-region sum and prioritised validation result.
    always_comb begin
        data_nxt = fat_start + product;
        err_nxt  = 3'd0;
        if (!(sig_lo_ok && sig_hi_ok))                           err_nxt = 3'd1;
        else if (bps != 16'(SECTOR_SIZE))                        err_nxt = 3'd2;
        else if (nfats == 8'd0)                                  err_nxt = 3'd3;
        else if ((spc == 8'd0) || ((spc & (spc - 8'd1)) != 8'd0)) err_nxt = 3'd4;
`ifdef BPB_TOTSEC_CHECK_EN
        else if ((data_nxt - part_lba) >= LBA_WIDTH'(tot_sec))   err_nxt = 3'd5;
`endif
    end

    // Parse result registers; cleared by start, loaded in CHECK.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err        <= '0;
            valid_q    <= 1'b0;
            data_start <= '0;
        end else if (bus.start) begin
            err        <= '0;
            valid_q    <= 1'b0;
        end else if (state == S_CHECK) begin
            err        <= err_nxt;
            valid_q    <= (err_nxt == 3'd0);
            data_start <= data_nxt;
        end
    end

    // Cluster offset: spc is a power of two once valid, so multiply is a shift.
    always_comb begin
        spc_log2 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (spc[i]) spc_log2 = 3'(i);
        end
        clus_off = '0;
        if (bus.cluster_in >= 32'd2) clus_off = LBA_WIDTH'(bus.cluster_in - 32'd2) << spc_log2;
        clus_nxt = data_start + clus_off;
`ifdef BPB_TOTSEC_CHECK_EN
        if (clus_nxt >= (part_lba + LBA_WIDTH'(tot_sec))) clus_nxt = '1;
`endif
    end

    // Translation port: registered result with a same-cycle ack pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack_q    <= 1'b0;
            clus_lba <= '0;
        end else begin
            ack_q <= xlate_ok;
            if (xlate_ok) clus_lba <= clus_nxt;
        end
    end

    assign bus.busy                = busy_w;
    assign bus.done                = (state == S_DONE);
    assign bus.valid               = valid_q;
    assign bus.error_code          = err;
    assign bus.reserved_sectors    = rsvd;
    assign bus.num_fats            = nfats;
    assign bus.fat_length          = fat_len;
    assign bus.sectors_per_cluster = spc;
    assign bus.root_cluster        = root_clus;
    assign bus.fat_start_lba       = fat_start;
    assign bus.data_start_lba      = data_start;
    assign bus.cluster_ack         = ack_q;
    assign bus.cluster_lba         = clus_lba;
    assign state_dbg               = state;
endmodule

// File: tb/tb_fat32_bpb_parser.sv
// Bench for fat32_bpb_parser: directed boot sectors, a field-level model
// of the expected parse outcome, and a per-cycle compare process.
module tb_fat32_bpb_parser;
    localparam int SECTOR_SIZE = 512;
    localparam int ADDR_WIDTH  = 10;
    localparam int LBA_WIDTH   = 32;

    typedef struct packed {
        logic [31:0] due;
        logic [2:0]  err;
        logic [15:0] rsvd;
        logic [7:0]  nf;
        logic [31:0] fl;
        logic [7:0]  spc;
        logic [31:0] root;
        logic [31:0] part;
        logic [31:0] tot;
        logic [31:0] fat_start;
        logic [31:0] data_start;
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] lba;
    } xexp_t;

    // ---------------- clock / reset ----------------
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] state_dbg;
    int         cyc = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    fat32_bpb_parser_if #(.ADDR_WIDTH(ADDR_WIDTH), .LBA_WIDTH(LBA_WIDTH)) bus ();

    fat32_bpb_parser #(
        .SECTOR_SIZE(SECTOR_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LBA_WIDTH  (LBA_WIDTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] sector [SECTOR_SIZE];
    exp_t       exp_q[$];
    xexp_t      xq[$];
    exp_t       cur;
    exp_t       e_pop;
    xexp_t      x_pop;
    bit         have_result = 1'b0;
    int         ack_count = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h) cycle=%0d", name, act, act, req, req, cyc);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] le(input int a, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = n - 1; i >= 0; i--) v = v * 32'd256 + 32'(sector[a + i]);
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] part);
        exp_t        m;
        logic [31:0] bps;
        bit          pow2;
        m           = '0;
        bps         = le(11, 2);
        m.spc       = sector[13];
        m.rsvd      = 16'(le(14, 2));
        m.nf        = sector[16];
        m.tot       = le(32, 4);
        m.fl        = le(36, 4);
        m.root      = le(44, 4);
        m.part      = part;
        m.fat_start = part + 32'(m.rsvd);
        m.data_start = m.fat_start + 32'(m.nf) * m.fl;
        pow2 = 1'b0;
        for (int k = 0; k < 8; k++) if (32'(m.spc) == (32'd1 << k)) pow2 = 1'b1;
        if (sector[510] != 8'h55 || sector[511] != 8'hAA) m.err = 3'd1;
        else if (bps != 32'(SECTOR_SIZE))                 m.err = 3'd2;
        else if (m.nf == 8'd0)                            m.err = 3'd3;
        else if (!pow2)                                   m.err = 3'd4;
`ifdef BPB_TOTSEC_CHECK_EN
        else if (m.data_start - part >= m.tot)            m.err = 3'd5;
`endif
        return m;
    endfunction

    function automatic logic [31:0] xmodel(input logic [31:0] cl);
        logic [31:0] r;
        if (cl < 32'd2) r = cur.data_start;
        else            r = cur.data_start + (cl - 32'd2) * 32'(cur.spc);
`ifdef BPB_TOTSEC_CHECK_EN
        if (r >= cur.part + cur.tot) r = 32'hFFFF_FFFF;
`endif
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("done_cycle", cyc, e_pop.due);
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                    chk("error_code", 32'(bus.error_code), 32'(e_pop.err));
                    chk("valid", 32'(bus.valid), 32'(e_pop.err == 3'd0));
                    chk("reserved_sectors", 32'(bus.reserved_sectors), 32'(e_pop.rsvd));
                    chk("num_fats", 32'(bus.num_fats), 32'(e_pop.nf));
                    chk("fat_length", bus.fat_length, e_pop.fl);
                    chk("sectors_per_cluster", 32'(bus.sectors_per_cluster), 32'(e_pop.spc));
                    chk("root_cluster", bus.root_cluster, e_pop.root);
                    chk("fat_start_lba", bus.fat_start_lba, e_pop.fat_start);
                    chk("data_start_lba", bus.data_start_lba, e_pop.data_start);
                    cur         = e_pop;
                    have_result = 1'b1;
                end
            end else if (exp_q.size() != 0 && cyc > int'(exp_q[0].due)) begin
                e_pop = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL done_missing actual=0 required=1 due_cycle=%0d cycle=%0d", e_pop.due, cyc);
            end else if (have_result && !bus.busy) begin
                chk("hold_valid", 32'(bus.valid), 32'(cur.err == 3'd0));
                chk("hold_error_code", 32'(bus.error_code), 32'(cur.err));
                chk("hold_data_start_lba", bus.data_start_lba, cur.data_start);
            end

            if (bus.cluster_ack) begin
                ack_count++;
                if (xq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    x_pop = xq.pop_front();
                    chk("ack_cycle", cyc, x_pop.due);
                    chk("cluster_lba", bus.cluster_lba, x_pop.lba);
                end
            end else if (xq.size() != 0 && cyc > int'(xq[0].due)) begin
                x_pop = xq.pop_front();
                checks++;
                errors++;
                $display("FAIL ack_missing actual=0 required=1 due_cycle=%0d cycle=%0d", x_pop.due, cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put(input int a, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) sector[a + i] = 8'((v >> (8 * i)) & 32'hFF);
    endtask

    task automatic build(input logic [15:0] bps, input logic [7:0] spc, input logic [15:0] rsvd,
                         input logic [7:0] nf, input logic [31:0] tot, input logic [31:0] fl,
                         input logic [31:0] root, input logic [7:0] s_lo, input logic [7:0] s_hi);
        for (int a = 0; a < SECTOR_SIZE; a++) sector[a] = 8'(a * 7 + 3);
        put(11, 2, 32'(bps));
        sector[13] = spc;
        put(14, 2, 32'(rsvd));
        sector[16] = nf;
        put(32, 4, tot);
        put(36, 4, fl);
        put(44, 4, root);
        sector[510] = s_lo;
        sector[511] = s_hi;
    endtask

    // mode 0: ascending, no gaps; mode 1: descending with random gaps, last byte last
    task automatic send_sector(input logic [31:0] part, input int n_bytes, input int mode);
        int   last_cyc;
        int   a;
        exp_t m;
        last_cyc = 0;
        @(posedge sys_clk); #1;
        have_result       = 1'b0;
        bus.start         = 1'b1;
        bus.partition_lba = part;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n_bytes; i++) begin
            if (mode == 0)                  a = i;
            else if (i == SECTOR_SIZE - 1)  a = SECTOR_SIZE - 1;
            else                            a = SECTOR_SIZE - 2 - i;
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                bus.byte_valid = 1'b0;
                @(posedge sys_clk); #1;
            end
            bus.byte_valid = 1'b1;
            bus.byte_addr  = ADDR_WIDTH'(a);
            bus.byte_data  = sector[a];
            last_cyc       = cyc;
            @(posedge sys_clk); #1;
        end
        bus.byte_valid = 1'b0;
        if (n_bytes == SECTOR_SIZE) begin
            m     = model(part);
            m.due = 32'(last_cyc + 10);
            exp_q.push_back(m);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge sys_clk); #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout actual=pending required=done cycle=%0d", cyc);
            exp_q.delete();
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic xreq(input logic [31:0] cl);
        xexp_t x;
        bus.cluster_req = 1'b1;
        bus.cluster_in  = cl;
        if (have_result && cur.err == 3'd0) begin
            x.due = 32'(cyc + 1);
            x.lba = xmodel(cl);
            xq.push_back(x);
        end
        @(posedge sys_clk); #1;
        bus.cluster_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic check_no_ack(input string name, input logic [31:0] cl);
        int n0;
        n0 = ack_count;
        xreq(cl);
        idle(2);
        chk(name, 32'(ack_count - n0), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start         = 1'b0;
        bus.partition_lba = '0;
        bus.byte_valid    = 1'b0;
        bus.byte_addr     = '0;
        bus.byte_data     = '0;
        bus.cluster_req   = 1'b0;
        bus.cluster_in    = '0;

        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_error_code", 32'(bus.error_code), 32'd0);
        chk("rst_data_start", bus.data_start_lba, 32'd0);
        chk("rst_cluster_lba", bus.cluster_lba, 32'd0);
        sys_rst = 1'b0;
        idle(2);

        // Nominal parse
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();
        chk("nom_fat_start_lit", bus.fat_start_lba, 32'd8224);
        chk("nom_data_start_lit", bus.data_start_lba, 32'd10146);
        chk("nom_err_lit", 32'(bus.error_code), 32'd0);
        chk("nom_valid_lit", 32'(bus.valid), 32'd1);

        // Translations, single then back-to-back
        xreq(32'd2);
        chk("x2_lit", bus.cluster_lba, 32'd10146);
        xreq(32'd5);
        chk("x5_lit", bus.cluster_lba, 32'd10170);
        xreq(32'd0);
        chk("x0_lit", bus.cluster_lba, 32'd10146);
        idle(1);
        xreq(32'd3);
        xreq(32'd100);
        xreq(32'd1);
        xreq(32'hFFFF_FFFF);
        idle(3);

        // Signature fault, then signature fault plus bad sector size
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAB);
        send_sector(32'd100, SECTOR_SIZE, 1);
        wait_done();
        chk("sig_err_lit", 32'(bus.error_code), 32'd1);
        chk("sig_valid_lit", 32'(bus.valid), 32'd0);
        build(16'd1024, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAB);
        send_sector(32'd100, SECTOR_SIZE, 0);
        wait_done();
        chk("sig_bps_prio_lit", 32'(bus.error_code), 32'd1);

        // Bad sector size alone
        build(16'd1024, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd100, SECTOR_SIZE, 0);
        wait_done();
        chk("bps_err_lit", 32'(bus.error_code), 32'd2);

        // spc=6, num_fats=0, spc=0, num_fats=0 with spc=6
        build(16'd512, 8'd6, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();
        chk("spc6_err_lit", 32'(bus.error_code), 32'd4);
        check_no_ack("spc6_no_ack", 32'd5);
        build(16'd512, 8'd8, 16'd32, 8'd0, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 1);
        wait_done();
        chk("nf0_err_lit", 32'(bus.error_code), 32'd3);
        check_no_ack("nf0_no_ack", 32'd5);
        build(16'd512, 8'd0, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();
        build(16'd512, 8'd6, 16'd32, 8'd0, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();

        // Large operands, wrap-around, out-of-order bytes with gaps
        build(16'd512, 8'd128, 16'hFFFF, 8'd255, 32'd1048576, 32'h0123_4567, 32'h0ABC_DEF0, 8'h55, 8'hAA);
        send_sector(32'hFFFF_0000, SECTOR_SIZE, 1);
        wait_done();
        xreq(32'd1000);
        xreq(32'd2);
        idle(3);

        // Abort after 200 bytes, then a full good sector
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, 200, 0);
        send_sector(32'd4096, SECTOR_SIZE, 0);
        wait_done();
        chk("abort_data_start_lit", bus.data_start_lba, 32'd6050);
        idle(15);

        // TotSec32 range checks
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd1000, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();
`ifdef BPB_TOTSEC_CHECK_EN
        chk("totsec_err_lit", 32'(bus.error_code), 32'd5);
`else
        chk("totsec_ignored_lit", 32'(bus.error_code), 32'd0);
`endif
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd100000, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        wait_done();
        chk("totsec_ok_valid_lit", 32'(bus.valid), 32'd1);
        xreq(32'd20000);
`ifdef BPB_TOTSEC_CHECK_EN
        chk("x20000_lit", bus.cluster_lba, 32'hFFFF_FFFF);
`else
        chk("x20000_lit", bus.cluster_lba, 32'd170130);
`endif
        idle(2);

        // Reset during COMPUTE
        build(16'd512, 8'd8, 16'd32, 8'd2, 32'd1048576, 32'd961, 32'd2, 8'h55, 8'hAA);
        send_sector(32'd8192, SECTOR_SIZE, 0);
        idle(2);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        sys_rst = 1'b1;
        exp_q.delete();
        have_result = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_error_code", 32'(bus.error_code), 32'd0);
        chk("mid_rst_reserved", 32'(bus.reserved_sectors), 32'd0);
        chk("mid_rst_num_fats", 32'(bus.num_fats), 32'd0);
        chk("mid_rst_fat_length", bus.fat_length, 32'd0);
        chk("mid_rst_spc", 32'(bus.sectors_per_cluster), 32'd0);
        chk("mid_rst_root", bus.root_cluster, 32'd0);
        chk("mid_rst_fat_start", bus.fat_start_lba, 32'd0);
        chk("mid_rst_data_start", bus.data_start_lba, 32'd0);
        chk("mid_rst_cluster_lba", bus.cluster_lba, 32'd0);
        idle(1);
        sys_rst = 1'b0;
        idle(20);
        chk("post_rst_done", 32'(bus.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end
endmodule
